// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program counter.
// Holds the sequencer state encoding, default vectors and the alignment mask helper.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

    // Mask that clears the low log2(inc) bits; inc is a power of two.
    function automatic logic [63:0] align_mask(input int unsigned inc);
        return ~(64'(inc) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_history.sv
// Shift buffer of recent fetch addresses; entry 0 (hist_pc LSBs) is the newest.
// Only instantiated when PC_HISTORY_EN is defined.
module pc_history #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned HIST_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         rec_en,
    input  logic [ADDR_W-1:0]            rec_pc,
    output logic [ADDR_W*HIST_DEPTH-1:0] hist_pc
);

    logic [ADDR_W-1:0] hist_q [HIST_DEPTH];
    logic [ADDR_W-1:0] hist_d [HIST_DEPTH];

    always_comb begin
        for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_d[i] = hist_q[i];
        end
        if (rec_en) begin
            hist_d[0] = rec_pc;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    // NOTE: this buffer is small and architecturally visible, so it is reset like
    // ordinary state; large storage arrays are normally left unreset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_pc[i*ADDR_W +: ADDR_W] = hist_q[i];
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: boot, sequential increment, redirect, exception and stall hold.
// Define PC_HISTORY_EN to add the hist_pc port and its history buffer.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEFAULT_EXC_VECTOR),
    parameter int unsigned       INC          = 4,
    parameter int unsigned       HIST_DEPTH   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              exception,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_inc,
    output logic              pc_valid,
    output logic              redirect_pending,
    output logic              addr_err
`ifdef PC_HISTORY_EN
    ,
    output logic [ADDR_W*HIST_DEPTH-1:0] hist_pc
`endif
);

    if (ADDR_W < 8 || INC < 4 || (INC & (INC - 1)) != 0 ||
        HIST_DEPTH == 0 || (HIST_DEPTH & (HIST_DEPTH - 1)) != 0) begin : g_bad_params
        $error("pc_sequencer: illegal ADDR_W, INC or HIST_DEPTH");
    end

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(INC));

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              addr_err_q, addr_err_d;

    logic [ADDR_W-1:0] target_aligned;
    logic              target_misaligned;

    assign pc_plus_inc       = pc_q + ADDR_W'(INC);
    assign target_aligned    = redirect_target & ALIGN_MASK;
    assign target_misaligned = |(redirect_target & ~ALIGN_MASK);

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        addr_err_d    = 1'b0;

        unique case (state_q)
            BOOT: state_d = RUN;

            RUN: begin
                if (exception) begin
                    pc_d          = EXC_VECTOR;
                    pend_target_d = '0;
                end else if (redirect_valid) begin
                    addr_err_d = target_misaligned;
                    if (stall) begin
                        pend_target_d = target_aligned;
                        state_d       = HOLD;
                    end else begin
                        pc_d = target_aligned;
                    end
                end else if (!stall) begin
                    pc_d = pc_plus_inc;
                end
            end

            HOLD: begin
                // A fresh redirect always supersedes the buffered one.
                if (exception) begin
                    pc_d          = EXC_VECTOR;
                    pend_target_d = '0;
                    state_d       = RUN;
                end else if (redirect_valid) begin
                    addr_err_d = target_misaligned;
                    if (stall) begin
                        pend_target_d = target_aligned;
                    end else begin
                        pc_d          = target_aligned;
                        pend_target_d = '0;
                        state_d       = RUN;
                    end
                end else if (!stall) begin
                    pc_d          = pend_target_q;
                    pend_target_d = '0;
                    state_d       = RUN;
                end
            end

            default: state_d = BOOT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            pend_target_q <= '0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign pc               = pc_q;
    assign pc_valid         = (state_q != BOOT);
    assign redirect_pending = (state_q == HOLD);
    assign addr_err         = addr_err_q;

`ifdef PC_HISTORY_EN
    logic hist_rec;

    // Record the address that becomes visible next cycle, whenever it is a new valid pc.
    assign hist_rec = !reset && (state_d != BOOT) && (pc_d != pc_q);

    pc_history #(
        .ADDR_W     (ADDR_W),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_pc_history (
        .clock   (clock),
        .reset   (reset),
        .rec_en  (hist_rec),
        .rec_pc  (pc_d),
        .hist_pc (hist_pc)
    );
`endif

endmodule
